// File: rtl/pipeline_chain_pkg.sv
// Shared sizing helpers for the valid/ready pipeline chain.
package pipeline_pkg;

  // Maximum number of items the chain can hold: one entry per stage, or two
  // when every stage carries a skid register.
  function automatic int unsigned cap_of(input int unsigned depth, input int unsigned skid);
    return depth * ((skid != 0) ? 2 : 1);
  endfunction

  // Width of a counter that must represent 0..cap inclusive.
  function automatic int unsigned occ_width(input int unsigned depth, input int unsigned skid);
    return $clog2(cap_of(depth, skid) + 1);
  endfunction

endpackage

// File: rtl/pipeline_chain_if.sv
// Valid/ready handshake bundle. The producer drives valid/data, the consumer
// drives ready.
interface pipeline_chain_if #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_chain_stage.sv
// One pipeline stage: a main register plus, in skid mode, a second register
// that catches the beat accepted while the main register is stalled.
module pipeline_stage #(
  parameter int W    = 32,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld_p0;
  logic [W-1:0] data_p0;

  assign out_valid = vld_p0;
  assign out_data  = data_p0;

  generate
    if (SKID != 0) begin : g_skid
      logic         skid_vld_p1;
      logic [W-1:0] skid_data_p1;

      // Ready is a pure register output: we can always take one more beat
      // unless the skid slot is already holding one.
      assign in_ready = ~skid_vld_p1;

      // Main/skid register update; the skid only fills behind a stalled main.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p0       <= 1'b0;
          data_p0      <= '0;
          skid_vld_p1  <= 1'b0;
          skid_data_p1 <= '0;
        end else if (flush) begin
          vld_p0      <= 1'b0;
          skid_vld_p1 <= 1'b0;
        end else if (!vld_p0) begin
          // Empty stage: the skid is necessarily empty too.
          if (in_valid) begin
            vld_p0  <= 1'b1;
            data_p0 <= in_data;
          end
        end else if (out_ready) begin
          // Head leaves; refill from skid first to keep FIFO order.
          if (skid_vld_p1) begin
            data_p0     <= skid_data_p1;
            skid_vld_p1 <= 1'b0;
          end else if (in_valid) begin
            data_p0 <= in_data;
          end else begin
            vld_p0 <= 1'b0;
          end
        end else if (in_valid && !skid_vld_p1) begin
          skid_vld_p1  <= 1'b1;
          skid_data_p1 <= in_data;
        end
      end
    end else begin : g_full
      // Bypass-ready: accept when empty or when the head leaves this cycle.
      assign in_ready = ~vld_p0 | out_ready;

      // Single-entry register, loaded whenever the stage is ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p0  <= 1'b0;
          data_p0 <= '0;
        end else if (flush) begin
          vld_p0 <= 1'b0;
        end else if (in_ready) begin
          vld_p0 <= in_valid;
          if (in_valid) begin
            data_p0 <= in_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipeline_chain.sv
// DEPTH-stage valid/ready pipeline with synchronous flush and an occupancy
// counter. SKID selects 2-entry skid stages (registered ready) or 1-entry
// bypass-ready stages.
module pipeline_chain
  import pipeline_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  parameter  int SKID  = 1,
  localparam int CAP   = int'(cap_of(DEPTH, SKID)),
  localparam int OCC_W = int'(occ_width(DEPTH, SKID))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipeline_chain_if.slave   up,
  pipeline_chain_if.master  dn,
  output logic [OCC_W-1:0]  occupancy
);

  // Handshake nets between stages; index i feeds stage i, index DEPTH is
  // the chain output.
  logic         vld_c [DEPTH+1];
  logic         rdy_c [DEPTH+1];
  logic [W-1:0] dat_c [DEPTH+1];

  logic acc;
  logic emit;

  // Flush blanks both external handshakes so no beat crosses the boundary
  // in the flush cycle; internal moves that cycle are discarded by the
  // stages' own flush.
  assign vld_c[0]     = up.valid & ~flush;
  assign dat_c[0]     = up.data;
  assign up.ready     = rdy_c[0] & ~flush;
  assign dn.valid     = vld_c[DEPTH] & ~flush;
  assign dn.data      = dat_c[DEPTH];
  assign rdy_c[DEPTH] = dn.ready & ~flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      pipeline_stage #(
        .W    (W),
        .SKID (SKID)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (vld_c[gi]),
        .in_ready  (rdy_c[gi]),
        .in_data   (dat_c[gi]),
        .out_valid (vld_c[gi+1]),
        .out_ready (rdy_c[gi+1]),
        .out_data  (dat_c[gi+1])
      );
    end
  endgenerate

  assign acc  = up.valid & up.ready;
  assign emit = dn.valid & dn.ready;

  // Occupancy tracks accepted minus emitted beats; flush empties the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(acc) - OCC_W'(emit);
    end
  end

endmodule

// File: tb/tb_pipeline_chain.sv
module tb_pipeline_chain;
  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int SKID  = 1;
  localparam int CAP   = 4;
  localparam int OCC_W = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occupancy;

  pipeline_chain_if #(.W(W)) up_if ();
  pipeline_chain_if #(.W(W)) dn_if ();

  pipeline_chain #(.W(W), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          occ_m = 0;
  int          last_lat = -1;
  int          n_emit = 0;
  int          n_acc = 0;
  bit          last_acc = 0;
  bit          last_emit = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, sample the
  // handshakes before the rising edge, update the scoreboard, move on.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input bit probe = 1'b0);
    up_if.valid = iv;
    up_if.data  = id;
    dn_if.ready = ordy;
    flush       = fl;
    #1;
    check("occupancy", 32'(occupancy), occ_m);
    if (probe) begin
      logic r0;
      r0 = up_if.ready;
      dn_if.ready = ~ordy;
      #1;
      check("in_ready_vs_out_ready", 32'(up_if.ready), 32'(r0));
      dn_if.ready = ordy;
      #1;
    end
    last_acc  = 1'b0;
    last_emit = 1'b0;
    if (fl) begin
      check("flush_in_ready", 32'(up_if.ready), 0);
      check("flush_out_valid", 32'(dn_if.valid), 0);
      exp_q.delete();
      cyc_q.delete();
      occ_m = 0;
    end else begin
      if (dn_if.valid && dn_if.ready) begin
        last_emit = 1'b1;
        if (exp_q.size() == 0) begin
          check("emit_with_nothing_pending", 32'(dn_if.valid), 0);
        end else begin
          check("out_data", dn_if.data, exp_q.pop_front());
          last_lat = cyc - cyc_q.pop_front();
          n_emit++;
          occ_m--;
        end
      end
      if (up_if.valid && up_if.ready) begin
        last_acc = 1'b1;
        exp_q.push_back(id);
        cyc_q.push_back(cyc);
        n_acc++;
        occ_m++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int base;
    int k;
    logic tog;
    up_if.valid = 1'b1;
    up_if.data  = 32'h0;
    dn_if.ready = 1'b1;

    // Reset held with in_valid asserted.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_out_valid", 32'(dn_if.valid), 0);
      check("rst_occupancy", 32'(occupancy), 0);
      check("rst_in_ready", 32'(up_if.ready), 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First item latency.
    cycle(1'b1, 32'hA5, 1'b1, 1'b0);
    #1;
    check("lat_not_early", 32'(dn_if.valid), 0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("first_latency", 32'(last_lat), DEPTH);

    // Streaming 0..99.
    base = n_emit;
    for (int i = 0; i < 100; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
    check("stream_emits_during_push", 32'(n_emit - base), 98);
    #1;
    check("stream_occupancy", 32'(occupancy), DEPTH);
    repeat (DEPTH + 1) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_total", 32'(n_emit - base), 100);

    // Backpressure fill then drain.
    k = 0;
    while (k < 20) begin
      cycle(1'b1, 32'(32'h300 + k), 1'b0, 1'b0);
      k++;
      if (!up_if.ready) break;
    end
    #1;
    check("bp_in_ready", 32'(up_if.ready), 0);
    check("bp_occupancy", 32'(occupancy), CAP);
    k = 0;
    while (k < 20 && exp_q.size() != 0) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    check("bp_drained", 32'(exp_q.size()), 0);

    // Toggling out_ready with random pushes; in_ready must not follow out_ready.
    base = n_acc;
    tog = 1'b0;
    for (int c = 0; c < 2000 && (n_acc - base) < 200; c++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, tog, 1'b0, 1'b1);
      tog = ~tog;
    end
    check("toggle_pushes", 32'(n_acc - base), 200);
    k = 0;
    while (k < 20 && exp_q.size() != 0) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    check("toggle_drained", 32'(exp_q.size()), 0);

    // Flush with three items held.
    cycle(1'b1, 32'h501, 1'b0, 1'b0);
    cycle(1'b1, 32'h502, 1'b0, 1'b0);
    cycle(1'b1, 32'h503, 1'b0, 1'b0);
    #1;
    check("pre_flush_occ", 32'(occupancy), 3);
    cycle(1'b1, 32'hDEAD, 1'b1, 1'b1);
    #1;
    check("post_flush_out_valid", 32'(dn_if.valid), 0);
    check("post_flush_occ", 32'(occupancy), 0);
    cycle(1'b1, 32'h1234, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_then_latency", 32'(last_lat), DEPTH);

    // Simultaneous accept/emit on a loaded chain, then async reset.
    cycle(1'b1, 32'h600, 1'b1, 1'b0);
    cycle(1'b1, 32'h601, 1'b1, 1'b0);
    cycle(1'b1, 32'h602, 1'b1, 1'b0);
    check("simul_accept", 32'(last_acc), 1);
    check("simul_emit", 32'(last_emit), 1);
    #1;
    check("simul_occ", 32'(occupancy), DEPTH);
    cycle(1'b1, 32'h603, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(dn_if.valid), 0);
    check("arst_out_data", dn_if.data, 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_in_ready", 32'(up_if.ready), 1);
    exp_q.delete();
    cyc_q.delete();
    occ_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h777, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_reset_latency", 32'(last_lat), DEPTH);
    check("post_reset_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
